// File: rtl/pipeline_mem_pkg.sv
// Shared types for the MEM stage: bus encodings, FSM states, payload structs and access sizing.
package pipeline_mem_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_LB   = 3'd1,
        RD_LBU  = 3'd2,
        RD_LH   = 3'd3,
        RD_LHU  = 3'd4,
        RD_LW   = 3'd5,
        RD_LWU  = 3'd6,
        RD_LD   = 3'd7
    } dm_rd_ctrl_e;

    // Codes 5..7 are not valid stores and decode as no access.
    typedef enum logic [2:0] {
        WR_NONE = 3'd0,
        WR_SB   = 3'd1,
        WR_SH   = 3'd2,
        WR_SW   = 3'd3,
        WR_SD   = 3'd4
    } dm_wr_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } dm_bus_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  mem_data;
        logic [REG_W-1:0] rd;
        logic             rf_wr_en;
        logic [SEL_W-1:0] rf_wr_sel;
        logic             misalign;
    } mem_wb_t;

    function automatic logic is_store(input logic [2:0] ctrl);
        return (ctrl == WR_SB) || (ctrl == WR_SH) || (ctrl == WR_SW) || (ctrl == WR_SD);
    endfunction

    function automatic logic [SIZE_W-1:0] wr_size(input logic [2:0] ctrl);
        logic [SIZE_W-1:0] sz;
        case (ctrl)
            WR_SB:   sz = SIZE_W'(1);
            WR_SH:   sz = SIZE_W'(2);
            WR_SW:   sz = SIZE_W'(4);
            WR_SD:   sz = SIZE_W'(8);
            default: sz = SIZE_W'(0);
        endcase
        return sz;
    endfunction

    function automatic logic [SIZE_W-1:0] rd_size(input logic [2:0] ctrl);
        logic [SIZE_W-1:0] sz;
        case (ctrl)
            RD_LB, RD_LBU: sz = SIZE_W'(1);
            RD_LH, RD_LHU: sz = SIZE_W'(2);
            RD_LW, RD_LWU: sz = SIZE_W'(4);
            RD_LD:         sz = SIZE_W'(8);
            default:       sz = SIZE_W'(0);
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data bus: store data/strobe shifting and load shift plus extension.
module load_store_align
    import pipeline_mem_pkg::*;
(
    input  logic [OFF_W-1:0]  off,
    input  logic [SIZE_W-1:0] size,
    input  logic [2:0]        rd_ctrl,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ld_data,
    output logic [XLEN-1:0]   wdata_c,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [XLEN-1:0]   ld_ext_c
);

    logic [5:0]          shamt;
    logic [STRB_W-1:0]   size_mask;
    logic [2*STRB_W-1:0] strb_wide;
    logic [XLEN-1:0]     ld_shifted;

    assign shamt = {off, 3'b000};

    always_comb begin
        size_mask = '0;
        case (size)
            SIZE_W'(1): size_mask = STRB_W'(8'h01);
            SIZE_W'(2): size_mask = STRB_W'(8'h03);
            SIZE_W'(4): size_mask = STRB_W'(8'h0F);
            SIZE_W'(8): size_mask = STRB_W'(8'hFF);
            default:    size_mask = '0;
        endcase
    end

    // Strobes are shifted in a double-width vector so lanes past byte 7 fall off cleanly.
    assign strb_wide = (2*STRB_W)'(size_mask) << off;
    assign wstrb_c   = strb_wide[STRB_W-1:0];
    assign wdata_c   = st_data << shamt;

    // Logical right shift zero-fills lanes above byte 7 before extension.
    assign ld_shifted = ld_data >> shamt;

    always_comb begin
        ld_ext_c = '0;
        case (rd_ctrl)
            RD_LB:   ld_ext_c = {{(XLEN-8){ld_shifted[7]}},   ld_shifted[7:0]};
            RD_LBU:  ld_ext_c = {{(XLEN-8){1'b0}},            ld_shifted[7:0]};
            RD_LH:   ld_ext_c = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            RD_LHU:  ld_ext_c = {{(XLEN-16){1'b0}},           ld_shifted[15:0]};
            RD_LW:   ld_ext_c = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            RD_LWU:  ld_ext_c = {{(XLEN-32){1'b0}},           ld_shifted[31:0]};
            RD_LD:   ld_ext_c = ld_shifted;
            default: ld_ext_c = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// RV64 memory-access stage: req/ack data bus sequencing, lane alignment and the MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on misalign_WB.
module pipeline_mem_stage
    import pipeline_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc_MEM,
    input  logic [XLEN-1:0]   alu_result_EX,
    input  logic [XLEN-1:0]   reg_data2_MEM,
    input  logic [REG_W-1:0]  rd_MEM,
    input  logic              rf_wr_en_EX,
    input  logic [SEL_W-1:0]  rf_wr_sel_EX,
    input  logic [2:0]        dm_rd_ctrl_EX,
    input  logic [2:0]        dm_wr_ctrl_EX,
    output logic              dm_req,
    output logic              dm_we,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    output logic [STRB_W-1:0] dm_wstrb,
    input  logic              dm_ack,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic              stall_MEM,
    output logic [XLEN-1:0]   pc_WB,
    output logic [XLEN-1:0]   alu_result_WB,
    output logic [XLEN-1:0]   mem_data_WB,
    output logic [REG_W-1:0]  rd_WB,
    output logic              rf_wr_en_WB,
    output logic [SEL_W-1:0]  rf_wr_sel_WB,
    output logic              misalign_WB
);

    mem_state_e state_q, state_d;
    logic       dm_req_q, dm_req_d;
    dm_bus_t    bus_q, bus_d;
    mem_wb_t    wb_q, wb_d;

    logic              wr_op;
    logic              rd_op;
    logic              mem_op;
    logic [SIZE_W-1:0] acc_size;
    logic              trap;
    logic              stall_c;
    mem_wb_t           wb_in;

    logic [XLEN-1:0]   wdata_c;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   ld_ext_c;

    // A store wins over a simultaneous load encoding.
    assign wr_op    = is_store(dm_wr_ctrl_EX);
    assign rd_op    = (dm_rd_ctrl_EX != RD_NONE) && !wr_op;
    assign mem_op   = wr_op || rd_op;
    assign acc_size = wr_op ? wr_size(dm_wr_ctrl_EX) : rd_size(dm_rd_ctrl_EX);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = mem_op && ((alu_result_EX[OFF_W-1:0] & OFF_W'(acc_size - SIZE_W'(1))) != '0);
`else
    assign trap = 1'b0;
`endif

    load_store_align u_align (
        .off      (alu_result_EX[OFF_W-1:0]),
        .size     (acc_size),
        .rd_ctrl  (dm_rd_ctrl_EX),
        .st_data  (reg_data2_MEM),
        .ld_data  (dm_rdata),
        .wdata_c  (wdata_c),
        .wstrb_c  (wstrb_c),
        .ld_ext_c (ld_ext_c)
    );

    always_comb begin
        wb_in            = '0;
        wb_in.pc         = pc_MEM;
        wb_in.alu_result = alu_result_EX;
        wb_in.rd         = rd_MEM;
        wb_in.rf_wr_en   = rf_wr_en_EX;
        wb_in.rf_wr_sel  = rf_wr_sel_EX;
    end

    // Next-state, bus and MEM/WB payload; WB defaults to a bubble.
    always_comb begin
        state_d  = state_q;
        dm_req_d = dm_req_q;
        bus_d    = bus_q;
        wb_d     = '0;
        stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    wb_d = wb_in;
                end else if (trap) begin
                    stall_c          = 1'b1;
                    wb_d             = wb_in;
                    wb_d.rf_wr_en    = 1'b0;
                    wb_d.misalign    = 1'b1;
                    state_d          = DONE;
                end else begin
                    stall_c     = 1'b1;
                    dm_req_d    = 1'b1;
                    bus_d.we    = wr_op;
                    bus_d.addr  = {alu_result_EX[XLEN-1:OFF_W], OFF_W'(0)};
                    bus_d.wdata = wr_op ? wdata_c : '0;
                    bus_d.wstrb = wr_op ? wstrb_c : '0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                stall_c = 1'b1;
                if (dm_ack) begin
                    dm_req_d      = 1'b0;
                    wb_d          = wb_in;
                    wb_d.mem_data = bus_q.we ? '0 : ld_ext_c;
                    state_d       = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            dm_req_q <= 1'b0;
            bus_q    <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            dm_req_q <= dm_req_d;
            bus_q    <= bus_d;
            wb_q     <= wb_d;
        end
    end

    assign stall_MEM     = stall_c;
    assign dm_req        = dm_req_q;
    assign dm_we         = bus_q.we;
    assign dm_addr       = bus_q.addr;
    assign dm_wdata      = bus_q.wdata;
    assign dm_wstrb      = bus_q.wstrb;
    assign pc_WB         = wb_q.pc;
    assign alu_result_WB = wb_q.alu_result;
    assign mem_data_WB   = wb_q.mem_data;
    assign rd_WB         = wb_q.rd;
    assign rf_wr_en_WB   = wb_q.rf_wr_en;
    assign rf_wr_sel_WB  = wb_q.rf_wr_sel;
    assign misalign_WB   = wb_q.misalign;

endmodule
